// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Helpers work on a fixed wide vector; callers size-cast in and out.
  localparam int DIV_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's-complement negation; the caller truncates to its own width,
  // which makes the result modulo 2^WIDTH.
  function automatic logic [DIV_MAX_W-1:0] neg_val(input logic [DIV_MAX_W-1:0] v);
    return ~v + DIV_MAX_W'(1);
  endfunction

  // Magnitude of a value whose sign has already been decided by the caller.
  function automatic logic [DIV_MAX_W-1:0] abs_val(input logic [DIV_MAX_W-1:0] v,
                                                   input logic              is_neg);
    return is_neg ? neg_val(v) : v;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only if it did not borrow.
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_shift_i,
  input  logic             shift_out_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_next_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   b_inv;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;

  // Subtraction as A + ~B + 1 on the ripple-carry chain.
  assign b_inv    = ~{1'b0, divisor_i};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    assign diff[i]      = rem_shift_i[i] ^ b_inv[i] ^ carry[i];
    assign carry[i+1]   = (rem_shift_i[i] & b_inv[i]) |
                          (carry[i] & (rem_shift_i[i] ^ b_inv[i]));
  end

  // Carry out means no borrow. A bit shifted out above the window means the
  // true shifted value already exceeds any divisor, so the subtract succeeds.
  assign q_bit_o    = carry[WIDTH+1] | shift_out_i;
  assign rem_next_o = q_bit_o ? diff : rem_shift_i;

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
//
// state | meaning
// IDLE  | ready for a request; zero divisor short-cuts straight to DONE
// RUN   | WIDTH shift/subtract iterations on operand magnitudes
// FIX   | apply result signs, load output registers
// DONE  | response valid, held until rsp_ready
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH:0]   p_q,     p_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] d_q,     d_d;
  logic             qneg_q,  qneg_d;
  logic             rneg_q,  rneg_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             dbz_q,   dbz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_bit;

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = WIDTH'(abs_val(DIV_MAX_W'(dividend), dvd_neg));
  assign dvs_mag = WIDTH'(abs_val(DIV_MAX_W'(divisor),  dvs_neg));

  // The dividend magnitude lives in Q and shifts into P one bit per cycle.
  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_shift_i (({p_q[WIDTH-1:0], q_q[WIDTH-1]})),
    .shift_out_i (p_q[WIDTH]),
    .divisor_i   (d_q),
    .rem_next_o  (step_rem),
    .q_bit_o     (step_bit)
  );

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (divisor == '0) begin
            quot_d  = '0;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = dvd_mag;
            d_d     = dvs_mag;
            p_d     = '0;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
            cnt_d   = CNT_W'(WIDTH);
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p_d   = step_rem;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quot_d  = qneg_q ? WIDTH'(neg_val(DIV_MAX_W'(q_q))) : q_q;
        rem_d   = rneg_q ? WIDTH'(neg_val(DIV_MAX_W'(p_q[WIDTH-1:0]))) : p_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
